// File: rtl/ascii_pkg.sv
// Shared ASCII constants and types for the binary-to-ASCII decimal streamer.
package ascii_pkg;

   localparam logic [6:0] ASCII_ZERO = 7'h30;
   localparam logic [6:0] ASCII_NINE = 7'h39;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_EMIT
   } dec_state_e;

   typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift in the next binary bit.
module bcd_dabble_step
   import ascii_pkg::*;
#(
   parameter int NUM_DIGITS = 5
) (
   input  logic [NUM_DIGITS*4:0]   bcd_i,
   output logic [NUM_DIGITS*4-1:0] bcd_o
);

   logic [NUM_DIGITS*4-1:0] adjusted;
   bcd_digit_t              digit;

   // bcd_i holds the current digits above bit 0, which is the next binary bit to shift in.
   always_comb begin
      adjusted = '0;
      digit    = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         digit = bcd_i[d*4+1 +: 4];
         adjusted[d*4 +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
      end
      bcd_o = {adjusted[NUM_DIGITS*4-2:0], bcd_i[0]};
   end

endmodule

// File: rtl/ascii_dec_streamer.sv
// Converts an unsigned binary value to BCD by double-dabble and streams it out as ASCII digits,
// most significant digit first, one character per out_valid/out_ready handshake.
module ascii_dec_streamer
   import ascii_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int NUM_DIGITS     = 5,
   parameter bit SUPPRESS_ZEROS = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       out_char,
   output logic             out_last,
   output logic             busy
);

   localparam int BCD_W = NUM_DIGITS * 4;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1;
   localparam longint unsigned DEC_LIMIT = 64'd10 ** NUM_DIGITS;

   if (DEC_LIMIT <= MAX_VALUE) begin : g_digit_check
      $error("ascii_dec_streamer: NUM_DIGITS too small to hold 2**WIDTH-1");
   end

   dec_state_e       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [BCD_W-1:0] stepBcd;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] entryPtr;
   logic             outValid_q, outValid_d;
   logic [6:0]       outChar_q, outChar_d;
   logic             outLast_q, outLast_d;

   function automatic bcd_digit_t digitAt(input logic [BCD_W-1:0] b, input logic [PTR_W-1:0] p);
      bcd_digit_t d;
      d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (p == PTR_W'(i)) d = b[i*4 +: 4];
      end
      return d;
   endfunction

   bcd_dabble_step #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_step (
      .bcd_i ({bcd_q, shift_q[WIDTH-1]}),
      .bcd_o (stepBcd)
   );

   // The highest nonzero digit wins; an all-zero result leaves the pointer at digit 0.
   always_comb begin
      entryPtr = PTR_W'(NUM_DIGITS - 1);
      if (SUPPRESS_ZEROS) begin
         entryPtr = '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) entryPtr = PTR_W'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      outValid_d = outValid_q;
      outChar_d  = outChar_q;
      outLast_d  = outLast_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shift_d = in_value;
               bcd_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = S_CONVERT;
            end
         end
         // The extra cycle with cnt_q==0 lets the first digit be loaded from the final BCD.
         S_CONVERT: begin
            if (cnt_q != '0) begin
               bcd_d   = stepBcd;
               shift_d = shift_q << 1;
               cnt_d   = cnt_q - 1'b1;
            end else begin
               state_d    = S_EMIT;
               ptr_d      = entryPtr;
               outValid_d = 1'b1;
               outChar_d  = ASCII_ZERO + {3'b000, digitAt(bcd_q, entryPtr)};
               outLast_d  = (entryPtr == '0);
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (ptr_q == '0) begin
                  state_d    = S_IDLE;
                  outValid_d = 1'b0;
                  outChar_d  = '0;
                  outLast_d  = 1'b0;
               end else begin
                  ptr_d     = ptr_q - 1'b1;
                  outChar_d = ASCII_ZERO + {3'b000, digitAt(bcd_q, ptr_q - 1'b1)};
                  outLast_d = (ptr_q == PTR_W'(1));
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ptr_q      <= '0;
         outValid_q <= 1'b0;
         outChar_q  <= '0;
         outLast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         outValid_q <= outValid_d;
         outChar_q  <= outChar_d;
         outLast_q  <= outLast_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = outValid_q;
   assign out_char  = outChar_q;
   assign out_last  = outLast_q;

endmodule

// File: tb/tb_ascii_dec_streamer.sv
// Directed bench for ascii_dec_streamer: one instance with zero suppression, one without.
module tb_ascii_dec_streamer;

   logic        clk;
   logic        rst;
   logic        inValid, inReady, outValid, outReady, outLast, busy;
   logic [15:0] inValue;
   logic [6:0]  outChar;
   logic        inValid1, inReady1, outValid1, outReady1, outLast1, busy1;
   logic [15:0] inValue1;
   logic [6:0]  outChar1;

   int checks = 0;
   int errors = 0;

   ascii_dec_streamer #(.WIDTH(16), .NUM_DIGITS(5), .SUPPRESS_ZEROS(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_value(inValue),
      .out_valid(outValid), .out_ready(outReady), .out_char(outChar), .out_last(outLast),
      .busy(busy)
   );

   ascii_dec_streamer #(.WIDTH(16), .NUM_DIGITS(5), .SUPPRESS_ZEROS(1'b0)) dutFull (
      .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1), .in_value(inValue1),
      .out_valid(outValid1), .out_ready(outReady1), .out_char(outChar1), .out_last(outLast1),
      .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Presents a value at a falling edge and returns at the falling edge after it is captured.
   task automatic applyStimulus(input bit alt, input logic [15:0] v);
      int waited = 0;
      @(negedge clk);
      if (alt) begin inValid1 = 1'b1; inValue1 = v; end
      else     begin inValid  = 1'b1; inValue  = v; end
      while (!(alt ? inReady1 : inReady) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) checkOutput("accept_timeout", 0, 1);
      @(negedge clk);
      inValid  = 1'b0;
      inValid1 = 1'b0;
   endtask

   task automatic waitValid(input bit alt, output int n);
      n = 1;
      while (!(alt ? outValid1 : outValid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("valid_timeout", 0, 1);
   endtask

   // Expected characters are left-aligned in exp, first character in bits [34:28].
   task automatic expectStream(input string tag, input bit alt, input logic [34:0] exp, input int n);
      int lat;
      waitValid(alt, lat);
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "_char"}, alt ? outChar1 : outChar, exp[34-7*i -: 7]);
         checkOutput({tag, "_last"}, alt ? outLast1 : outLast, (i == n - 1));
         @(negedge clk);
      end
      checkOutput({tag, "_valid_done"}, alt ? outValid1 : outValid, 0);
      checkOutput({tag, "_ready_done"}, alt ? inReady1 : inReady, 1);
   endtask

   logic [6:0] got[$];
   int         lat;

   initial begin
      rst = 1'b1; inValid = 0; inValue = 0; outReady = 1; inValid1 = 0; inValue1 = 0; outReady1 = 1;
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", inReady, 1);
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_out_char", outChar, 7'h00);
      checkOutput("rst_out_last", outLast, 0);
      checkOutput("rst_busy", busy, 0);
      rst = 1'b0;

      $display("[TB] value 0");
      applyStimulus(0, 16'd0);
      expectStream("zero", 0, {7'h30, 28'h0}, 1);

      $display("[TB] value 65535 with latency");
      applyStimulus(0, 16'd65535);
      checkOutput("max_busy", busy, 1);
      checkOutput("max_in_ready", inReady, 0);
      waitValid(0, lat);
      checkOutput("max_latency", lat - 1, 17);
      expectStream("max", 0, {7'h36, 7'h35, 7'h35, 7'h33, 7'h35}, 5);

      $display("[TB] value 1207 both modes");
      applyStimulus(0, 16'd1207);
      expectStream("v1207", 0, {7'h31, 7'h32, 7'h30, 7'h37, 7'h00}, 4);
      applyStimulus(1, 16'd1207);
      expectStream("v1207_full", 1, {7'h30, 7'h31, 7'h32, 7'h30, 7'h37}, 5);

      $display("[TB] backpressure on 42");
      outReady = 1'b0;
      applyStimulus(0, 16'd42);
      waitValid(0, lat);
      for (int i = 0; i < 3; i++) begin
         checkOutput("bp_hold_char", outChar, 7'h34);
         checkOutput("bp_hold_last", outLast, 0);
         @(negedge clk);
      end
      outReady = 1'b1;
      expectStream("bp", 0, {7'h34, 7'h32, 21'h0}, 2);

      $display("[TB] reset mid-stream");
      applyStimulus(0, 16'd65535);
      waitValid(0, lat);
      checkOutput("rs_first", outChar, 7'h36);
      @(negedge clk);
      checkOutput("rs_second", outChar, 7'h35);
      rst = 1'b1;
      #1;
      checkOutput("rs_out_valid", outValid, 0);
      checkOutput("rs_busy", busy, 0);
      checkOutput("rs_out_char", outChar, 7'h00);
      checkOutput("rs_in_ready", inReady, 1);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 16'd9);
      expectStream("nine", 0, {7'h39, 28'h0}, 1);

      $display("[TB] back-to-back 10 20 30");
      got.delete();
      fork
         begin
            logic [15:0] vals [3];
            int waited;
            vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30;
            @(negedge clk);
            inValid = 1'b1;
            for (int i = 0; i < 3; i++) begin
               inValue = vals[i];
               waited = 0;
               while (!inReady && waited < 200) begin
                  @(negedge clk);
                  waited++;
               end
               if (waited >= 200) checkOutput("b2b_accept_timeout", 0, 1);
               @(negedge clk);
            end
            inValid = 1'b0;
         end
         begin
            for (int c = 0; c < 400 && got.size() < 6; c++) begin
               @(negedge clk);
               if (outValid) got.push_back(outChar);
            end
         end
      join
      checkOutput("b2b_count", got.size(), 6);
      if (got.size() == 6) begin
         logic [41:0] expSeq;
         expSeq = {7'h31, 7'h30, 7'h32, 7'h30, 7'h33, 7'h30};
         for (int i = 0; i < 6; i++) begin
            checkOutput("b2b_char", got[i], expSeq[41-7*i -: 7]);
            checkOutput("b2b_range", (got[i] >= 7'h30 && got[i] <= 7'h39), 1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
